counter_delta_sched: RTL

COUNTER_DELTA_SCHED -- requirements
Module: counter_delta_sched

---
 rtl/counter_delta_sched_pkg.sv | 19 +
 rtl/counter_shadow.sv | 35 +++
 rtl/counter_delta_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/counter_delta_sched_pkg.sv
// Shared types for the counter delta scheduler.
package counter_delta_sched_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef logic signed [5:0] pend_t;

    localparam int PEND_MAX_DEF = 16;
    localparam logic [2:0] AMT_MAX = 3'd4;

    function automatic logic [2:0] sat_amt(input logic [2:0] a);
        return (a > AMT_MAX) ? AMT_MAX : a;
    endfunction

endpackage

// File: rtl/counter_shadow.sv
// 4-bit modulo mirror of the downstream counter value.
module counter_shadow
    import counter_delta_sched_pkg::*;
#(
    parameter logic [3:0] INIT_VALUE = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       incr_valid,
    input  logic [1:0] incr,
    input  logic       decr_valid,
    input  logic [1:0] decr,
    output logic [3:0] value
);

    logic [3:0] add;
    logic [3:0] sub;

    always_comb begin
        add = incr_valid ? {2'b00, incr} : 4'd0;
        sub = decr_valid ? {2'b00, decr} : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= INIT_VALUE;
        end else if (load) begin
            value <= INIT_VALUE;
        end else begin
            value <= value + add - sub;
        end
    end

endmodule

// File: rtl/counter_delta_sched.sv
// Accumulates up/down events into a pending delta and
// meters it out as +/-1 or +/-2 commands to a counter.
module counter_delta_sched
    import counter_delta_sched_pkg::*;
#(
    parameter logic [3:0] INIT_VALUE = 4'h0,
    parameter int         PEND_MAX   = PEND_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_valid,
    input  logic [2:0] up_amt,
    output logic       up_ready,
    input  logic       dn_valid,
    input  logic [2:0] dn_amt,
    output logic       dn_ready,
    input  logic       clr_req,
    input  logic       flush_req,
    output logic       flush_done,
    output logic       incr_valid,
    output logic [1:0] incr,
    output logic       decr_valid,
    output logic [1:0] decr,
    output logic       reinit,
    output logic [3:0] shadow_value
);

    localparam pend_t P_HI  = pend_t'(PEND_MAX - 4);
    localparam pend_t P_LO  = -P_HI;
    localparam pend_t P_ZR  = 6'sd0;
    localparam pend_t P_ONE = 6'sd1;
    localparam pend_t P_TWO = 6'sd2;
    localparam pend_t P_M1  = -6'sd1;
    localparam pend_t P_M2  = -6'sd2;

    state_t state;
    pend_t  p;

    logic              up_acc;
    logic              dn_acc;
    logic signed [6:0] p_ext;
    logic signed [6:0] up_add;
    logic signed [6:0] dn_sub;
    logic signed [6:0] inc_s;
    logic signed [6:0] dec_s;
    logic signed [6:0] p_sum;
    logic              shadow_load;

    // Handshake: only RUN takes events, with 4 units of headroom.
    always_comb begin
        up_ready = (state == RUN) && (p <= P_HI);
        dn_ready = (state == RUN) && (p >= P_LO);
        up_acc   = up_valid && up_ready;
        dn_acc   = dn_valid && dn_ready;
    end

    always_comb begin
        incr_valid = 1'b0;
        incr       = 2'd0;
        decr_valid = 1'b0;
        decr       = 2'd0;
        if (state != CLEAR) begin
            unique case (1'b1)
                (p >= P_TWO): begin
                    incr_valid = 1'b1;
                    incr       = 2'd2;
                end
                (p == P_ONE): begin
                    incr_valid = 1'b1;
                    incr       = 2'd1;
                end
                (p == P_ZR): begin
                end
                (p == P_M1): begin
                    decr_valid = 1'b1;
                    decr       = 2'd1;
                end
                (p <= P_M2): begin
                    decr_valid = 1'b1;
                    decr       = 2'd2;
                end
            endcase
        end
    end

    always_comb begin
        reinit     = (state == CLEAR);
        flush_done = (state == DRAIN) && (p == P_ZR);
    end

    always_comb begin
        p_ext  = {p[5], p};
        up_add = up_acc ? {4'b0000, sat_amt(up_amt)} : 7'sd0;
        dn_sub = dn_acc ? {4'b0000, sat_amt(dn_amt)} : 7'sd0;
        inc_s  = {5'b00000, incr};
        dec_s  = {5'b00000, decr};
        p_sum  = p_ext + up_add - dn_sub - inc_s + dec_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            p     <= P_ZR;
        end else begin
            unique case (state)
                RUN: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        p     <= P_ZR;
                    end else begin
                        p <= p_sum[5:0];
                        if (flush_req) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        p     <= P_ZR;
                    end else begin
                        p <= p_sum[5:0];
                        if (p == P_ZR) begin
                            state <= RUN;
                        end
                    end
                end
                CLEAR: begin
                    p     <= P_ZR;
                    state <= clr_req ? CLEAR : RUN;
                end
                default: begin
                    state <= RUN;
                    p     <= P_ZR;
                end
            endcase
        end
    end

    // The mirror follows the reinit: it shows INIT_VALUE while CLEAR is up.
    assign shadow_load = clr_req || (state == CLEAR);

    counter_shadow #(
        .INIT_VALUE(INIT_VALUE)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .load       (shadow_load),
        .incr_valid (incr_valid),
        .incr       (incr),
        .decr_valid (decr_valid),
        .decr       (decr),
        .value      (shadow_value)
    );

endmodule
